decode_issue_ctrl: RTL



---
 rtl/decode_issue_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/decode_issue_ctrl.sv
// rtl/decode_issue_ctrl.sv - fetch-to-decode issue controller with a small instruction FIFO
// Optional: define DECODE_ISSUE_STATS_EN to add the issue_count / stall_cycles counters.
module decode_issue_ctrl #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fetch_valid,
    output logic             fetch_ready,
    input  logic [15:0]      fetch_instr,
    input  logic [15:0]      fetch_pc,
    input  logic             dec_stall,
    input  logic             flush,
    output logic             enable_decode,
    output logic [15:0]      instr_dout,
    output logic [15:0]      npc_in,
    output logic [PTR_W:0]   occupancy
`ifdef DECODE_ISSUE_STATS_EN
    ,
    output logic [15:0]      issue_count,
    output logic [15:0]      stall_cycles
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STALL, S_FLUSH} state_t;

    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_occ;
    logic [PTR_W:0]   w_occ_nxt;
    logic [15:0]      r_instr_mem [DEPTH];
    logic [15:0]      r_pc_mem    [DEPTH];
    logic             w_fetch_ready;
    logic             w_push;
    logic             w_pop;

    // The occupancy count, not the pointers, decides full and empty.
    assign w_fetch_ready = (r_occ != FULL_CNT) && (r_state != S_FLUSH) && reset;
    assign w_push        = fetch_valid && w_fetch_ready && !flush;
    assign w_pop         = ((r_state == S_IDLE) || (r_state == S_ISSUE)) &&
                           (r_occ != '0) && !dec_stall && !flush;

    assign fetch_ready = w_fetch_ready;
    assign occupancy   = r_occ;

    // Occupancy after this edge, ignoring flush (flush clears it outright).
    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_nxt = r_occ + 1'b1;
            2'b01:   w_occ_nxt = r_occ - 1'b1;
            default: w_occ_nxt = r_occ;
        endcase
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_FLUSH;
        end else begin
            case (r_state)
                S_IDLE:  if (w_occ_nxt != '0) w_state_nxt = S_ISSUE;
                S_ISSUE: begin
                    if (dec_stall && (r_occ != '0)) w_state_nxt = S_STALL;
                    else if (w_occ_nxt == '0)       w_state_nxt = S_IDLE;
                end
                S_STALL: if (!dec_stall) w_state_nxt = S_ISSUE;
                S_FLUSH: w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // State, pointers and occupancy; a flush empties the FIFO on the edge it is seen.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_occ    <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                r_occ <= w_occ_nxt;
            end
        end
    end

    // FIFO storage needs no reset; occupancy guards every read.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= fetch_instr;
            r_pc_mem[r_wr_ptr]    <= fetch_pc;
        end
    end

    // Decode-side outputs: a pop loads the head, otherwise only the strobe drops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enable_decode <= 1'b0;
            instr_dout    <= 16'h0000;
            npc_in        <= 16'h0000;
        end else begin
            enable_decode <= w_pop;
            if (w_pop) begin
                instr_dout <= r_instr_mem[r_rd_ptr];
                npc_in     <= r_pc_mem[r_rd_ptr] + 16'h0001;
            end
        end
    end

`ifdef DECODE_ISSUE_STATS_EN
    // Saturating issue and stall-cycle counters, cleared by flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            issue_count  <= 16'h0000;
            stall_cycles <= 16'h0000;
        end else if (flush) begin
            issue_count  <= 16'h0000;
            stall_cycles <= 16'h0000;
        end else begin
            if (w_pop && (issue_count != 16'hFFFF))
                issue_count <= issue_count + 16'h0001;
            if ((r_state == S_STALL) && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'h0001;
        end
    end
`endif

endmodule
